// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and constants for the CHIP-8 8XYn execution path.
// Holds the sequencer state enum, opcode nibble codes, ALU select codes and
// small decode helpers used by the sequencer, the ALU and the register file.
package chip8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB_X = 3'd3,
    ST_WB_F = 3'd4
  } seq_state_t;

  // Instruction class nibble for register-register ops.
  localparam logic [3:0] OP_CLASS_RR = 4'h8;

  // Low-nibble (n) codes of 8XYn.
  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_SUBN = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'hE;

  // ALU operation select codes.
  localparam logic [2:0] ALU_SHL  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_SUBN = 3'd7;

  localparam logic [3:0] VF_IDX = 4'hF;

  function automatic logic op_legal(input logic [15:0] op);
    return (op[15:12] == OP_CLASS_RR) && ((op[3] == 1'b0) || (op[3:0] == OP_SHL));
  endfunction

  // Ops whose carry/borrow/shifted-out bit is written to VF.
  function automatic logic op_sets_flag(input logic [3:0] n);
    return (n == OP_ADD) || (n == OP_SUB) || (n == OP_SHR) ||
           (n == OP_SUBN) || (n == OP_SHL);
  endfunction

  // SHL is the only legal nibble whose low three bits do not already match its select.
  function automatic logic [2:0] alu_sel(input logic [3:0] n);
    return (n == OP_SHL) ? ALU_SHL : n[2:0];
  endfunction

endpackage

// File: rtl/ALU.sv
// ALU: combinational 8-bit CHIP-8 arithmetic/logic unit.
// Ports: op (select), x/y (operands), out (result), carry_out (carry, NOT borrow,
// or shifted-out bit depending on op). Zero latency, no flow control.
module ALU
  import chip8_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] out,
  output logic       carry_out
);

  always_comb begin
    out       = 8'h00;
    carry_out = 1'b0;
    case (op)
      ALU_OR:   out = x | y;
      ALU_AND:  out = x & y;
      ALU_XOR:  out = x ^ y;
      ALU_ADD:  {carry_out, out} = {1'b0, x} + {1'b0, y};
      ALU_SUB: begin
        out       = x - y;
        carry_out = (x >= y);
      end
      ALU_SHR: begin
        out       = {1'b0, x[7:1]};
        carry_out = x[0];
      end
      ALU_SUBN: begin
        out       = y - x;
        carry_out = (y >= x);
      end
      ALU_SHL: begin
        out       = {x[6:0], 1'b0};
        carry_out = x[7];
      end
    endcase
  end

endmodule

// File: rtl/chip8_regfile.sv
// chip8_regfile: V0-VF register array, one synchronous write port, three
// combinational read ports (X, Y, debug). Writes visible the cycle after
// their edge; synchronous clear on reset. No flow control.
module chip8_regfile (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] x_addr,
  input  logic [3:0] y_addr,
  input  logic [3:0] dbg_addr,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign x_data   = regs[x_addr];
  assign y_data   = regs[y_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/chip8_alu_sequencer.sv
// chip8_alu_sequencer: runs one 8XYn instruction through the external ALU and
// writes back Vx then VF. Latency: done pulses the cycle after edge 4 (legal)
// or edge 0 (illegal). start and ext_we are ignored while busy; no queueing.
// Ports: clk/reset; start/opcode/busy/done/illegal to the decoder;
// alu_op/alu_x/alu_y/alu_out/alu_carry to the ALU; ext_* external write;
// dbg_addr/dbg_data combinational register peek.
module chip8_alu_sequencer
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        ext_we,
  input  logic [3:0]  ext_addr,
  input  logic [7:0]  ext_wdata,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  seq_state_t state, state_nxt;

  // Fields of the accepted instruction, held for the whole flight.
  logic [3:0] n_q;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic [7:0] res_q;
  logic       flag_q;

  logic       accept;
  logic       accept_illegal;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_x;
  logic [7:0] rf_y;

  chip8_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .x_addr   (x_q),
    .y_addr   (y_q),
    .dbg_addr (dbg_addr),
    .x_data   (rf_x),
    .y_data   (rf_y),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the single register-file write port mux.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    accept_illegal = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = x_q;
    rf_wdata       = res_q;
    case (state)
      ST_IDLE: begin
        // The external write shares the accept edge, so READ sees it.
        if (ext_we) begin
          rf_we    = 1'b1;
          rf_waddr = ext_addr;
          rf_wdata = ext_wdata;
        end
        if (start) begin
          if (op_legal(opcode)) begin
            accept    = 1'b1;
            state_nxt = ST_READ;
          end else begin
            accept_illegal = 1'b1;
          end
        end
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB_X;
      ST_WB_X: begin
        rf_we     = 1'b1;
        state_nxt = ST_WB_F;
      end
      ST_WB_F: begin
        // Flag lands after the result, so with X=F the flag wins.
        if (op_sets_flag(n_q)) begin
          rf_we    = 1'b1;
          rf_waddr = VF_IDX;
          rf_wdata = {7'b0, flag_q};
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      illegal <= 1'b0;
      n_q     <= 4'h0;
      x_q     <= 4'h0;
      y_q     <= 4'h0;
      alu_op  <= 3'd0;
      alu_x   <= 8'h00;
      alu_y   <= 8'h00;
      res_q   <= 8'h00;
      flag_q  <= 1'b0;
    end else begin
      done    <= accept_illegal || (state == ST_WB_F);
      illegal <= accept_illegal;
      if (accept) begin
        n_q <= opcode[3:0];
        x_q <= opcode[11:8];
        y_q <= opcode[7:4];
      end
      // Operands are latched here, so a Y=F source sees the pre-instruction VF.
      if (state == ST_READ) begin
        alu_x  <= rf_x;
        alu_y  <= rf_y;
        alu_op <= alu_sel(n_q);
      end
      if (state == ST_EXEC) begin
        res_q  <= (n_q == OP_LD) ? alu_y : alu_out;
        flag_q <= alu_carry;
      end
    end
  end

endmodule
